// File: rtl/frontend_a_seq_if.sv
// frontend_a_seq_if: groups the engine-side (Channel B) and pin-side
// (Channel A) signals of frontend_a_seq. The slave modport is the frontend
// itself; the master modport is its environment (engine plus board pins).
interface frontend_a_seq_if #(
  parameter int BUS_WIDTH = 8
);
  logic                 enable;
  logic [BUS_WIDTH-1:0] a_bus_in_n;
  logic                 a_bus_in_parity_n;
  logic [9:0]           a_tags_in_n;
  logic [BUS_WIDTH-1:0] a_bus_out;
  logic                 a_bus_out_parity;
  logic [10:0]          a_tags_out;
  logic                 driver_enable;
  logic [BUS_WIDTH-1:0] b_bus_in;
  logic                 b_bus_in_parity;
  logic [9:0]           b_tags_in;
  logic [BUS_WIDTH-1:0] b_bus_out;
  logic                 b_bus_out_parity;
  logic [10:0]          b_tags_out;
  logic [1:0]           state;

  modport slave (
    input  enable,
    input  a_bus_in_n,
    input  a_bus_in_parity_n,
    input  a_tags_in_n,
    output a_bus_out,
    output a_bus_out_parity,
    output a_tags_out,
    output driver_enable,
    output b_bus_in,
    output b_bus_in_parity,
    output b_tags_in,
    input  b_bus_out,
    input  b_bus_out_parity,
    input  b_tags_out,
    output state
  );

  modport master (
    output enable,
    output a_bus_in_n,
    output a_bus_in_parity_n,
    output a_tags_in_n,
    input  a_bus_out,
    input  a_bus_out_parity,
    input  a_tags_out,
    input  driver_enable,
    input  b_bus_in,
    input  b_bus_in_parity,
    input  b_tags_in,
    output b_bus_out,
    output b_bus_out_parity,
    output b_tags_out,
    input  state
  );
endinterface

// File: rtl/frontend_a_seq.sv
// frontend_a_seq: Channel "A" pin frontend with parametrised bus width,
// inbound synchronisers, per-bit tag glitch filter and a sequenced driver
// power-up/power-down state machine (OFF -> ARM -> ON -> DRAIN -> OFF).
//
// Optional feature: define FRONTEND_GLITCH_COUNT_EN to add the
// glitch_count_clear / glitch_count ports and the saturating glitch counter.
module frontend_a_seq #(
  parameter int BUS_WIDTH     = 8,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 3,
  parameter int GUARD_CYCLES  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
`ifdef FRONTEND_GLITCH_COUNT_EN
  input  logic              glitch_count_clear,
  output logic [15:0]       glitch_count,
`endif
  frontend_a_seq_if.slave   bus
);

  localparam int TAG_IN_W  = 10;
  localparam int TAG_OUT_W = 11;
  localparam int IN_W      = BUS_WIDTH + 1 + TAG_IN_W;
  localparam int RUN_W     = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
  localparam int CNT_W     = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
  localparam logic [RUN_W-1:0] RUN_LAST   = RUN_W'(FILTER_CYCLES - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_ARM   = 2'd1,
    ST_ON    = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  // Inbound synchroniser chain and de-inverted samples
  logic [IN_W-1:0]                   raw_in_s;
  logic [SYNC_STAGES-1:0][IN_W-1:0]  sync_r;
  logic [IN_W-1:0]                   sample_s;
  logic [BUS_WIDTH-1:0]              bus_sample_s;
  logic                              par_sample_s;
  logic [TAG_IN_W-1:0]               tag_sample_s;

  // Tag filter
  logic [TAG_IN_W-1:0]               filt_r;
  logic [TAG_IN_W-1:0]               filt_next_s;
  logic [TAG_IN_W-1:0][RUN_W-1:0]    run_r;
  logic [TAG_IN_W-1:0][RUN_W-1:0]    run_next_s;

  // Sequencer
  state_t                            state_r;
  state_t                            state_next_s;
  logic [CNT_W-1:0]                  guard_r;
  logic [CNT_W-1:0]                  guard_next_s;

  // Registered outputs
  logic                              driver_enable_r;
  logic [BUS_WIDTH-1:0]              a_bus_out_r;
  logic                              a_bus_out_parity_r;
  logic [TAG_OUT_W-1:0]              a_tags_out_r;
  logic [BUS_WIDTH-1:0]              b_bus_in_r;
  logic                              b_bus_in_parity_r;
  logic [TAG_IN_W-1:0]               b_tags_in_r;

  assign raw_in_s     = {bus.a_tags_in_n, bus.a_bus_in_parity_n, bus.a_bus_in_n};
  assign sample_s     = ~sync_r[SYNC_STAGES-1];
  assign bus_sample_s = sample_s[BUS_WIDTH-1:0];
  assign par_sample_s = sample_s[BUS_WIDTH];
  assign tag_sample_s = sample_s[IN_W-1:BUS_WIDTH+1];

  // Synchroniser flops for every inbound pin, parked deasserted (all ones) in reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_r <= '1;
    end else begin
      sync_r[0] <= raw_in_s;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_r[i] <= sync_r[i-1];
      end
    end
  end

  // Filter next-state: a differing sample extends the run, a matching one ends it.
  always_comb begin
    filt_next_s = filt_r;
    run_next_s  = run_r;
    for (int i = 0; i < TAG_IN_W; i++) begin
      if (tag_sample_s[i] != filt_r[i]) begin
        if (run_r[i] == RUN_LAST) begin
          filt_next_s[i] = tag_sample_s[i];
          run_next_s[i]  = '0;
        end else begin
          run_next_s[i]  = run_r[i] + RUN_W'(1);
        end
      end else begin
        run_next_s[i] = '0;
      end
    end
  end

  // Filter state register; runs in every sequencer state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filt_r <= '0;
      run_r  <= '0;
    end else begin
      filt_r <= filt_next_s;
      run_r  <= run_next_s;
    end
  end

`ifdef FRONTEND_GLITCH_COUNT_EN
  logic [TAG_IN_W-1:0] abandon_s;
  logic [15:0]         glitch_count_r;

  // A bit abandons its run when the sample falls back to the filter value mid-run.
  always_comb begin
    abandon_s = '0;
    for (int i = 0; i < TAG_IN_W; i++) begin
      if (tag_sample_s[i] == filt_r[i]) begin
        abandon_s[i] = (run_r[i] != '0);
      end else begin
        abandon_s[i] = 1'b0;
      end
    end
  end

  // Glitch event counter: clear beats increment, increments saturate at all ones.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      glitch_count_r <= 16'h0000;
    end else if (glitch_count_clear) begin
      glitch_count_r <= 16'h0000;
    end else if ((|abandon_s) && (glitch_count_r != 16'hFFFF)) begin
      glitch_count_r <= glitch_count_r + 16'h0001;
    end else begin
      glitch_count_r <= glitch_count_r;
    end
  end

  assign glitch_count = glitch_count_r;
`endif

  // Sequencer state and guard counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_OFF;
      guard_r <= '0;
    end else begin
      state_r <= state_next_s;
      guard_r <= guard_next_s;
    end
  end

  // Sequencer next-state: guard time is spent in ARM before outputs go live and in DRAIN after.
  always_comb begin
    state_next_s = state_r;
    guard_next_s = guard_r;
    case (state_r)
      ST_OFF: begin
        if (bus.enable) begin
          state_next_s = ST_ARM;
          guard_next_s = '0;
        end else begin
          state_next_s = ST_OFF;
          guard_next_s = '0;
        end
      end
      ST_ARM: begin
        if (!bus.enable) begin
          state_next_s = ST_DRAIN;
          guard_next_s = '0;
        end else if (guard_r == GUARD_LAST) begin
          state_next_s = ST_ON;
          guard_next_s = '0;
        end else begin
          state_next_s = ST_ARM;
          guard_next_s = guard_r + CNT_W'(1);
        end
      end
      ST_ON: begin
        if (!bus.enable) begin
          state_next_s = ST_DRAIN;
          guard_next_s = '0;
        end else begin
          state_next_s = ST_ON;
          guard_next_s = '0;
        end
      end
      ST_DRAIN: begin
        // enable is deliberately ignored here: a drain always runs to completion.
        if (guard_r == GUARD_LAST) begin
          state_next_s = ST_OFF;
          guard_next_s = '0;
        end else begin
          state_next_s = ST_DRAIN;
          guard_next_s = guard_r + CNT_W'(1);
        end
      end
      default: begin
        state_next_s = ST_OFF;
        guard_next_s = '0;
      end
    endcase
  end

  // Output registers gated by the state being entered, so outputs track state with no extra lag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      driver_enable_r    <= 1'b0;
      a_bus_out_r        <= '0;
      a_bus_out_parity_r <= 1'b0;
      a_tags_out_r       <= '0;
      b_bus_in_r         <= '0;
      b_bus_in_parity_r  <= 1'b0;
      b_tags_in_r        <= '0;
    end else begin
      driver_enable_r <= (state_next_s != ST_OFF);
      if (state_next_s == ST_ON) begin
        a_bus_out_r        <= bus.b_bus_out;
        a_bus_out_parity_r <= bus.b_bus_out_parity;
        a_tags_out_r       <= bus.b_tags_out;
        b_bus_in_r         <= bus_sample_s;
        b_bus_in_parity_r  <= par_sample_s;
        b_tags_in_r        <= filt_next_s;
      end else begin
        a_bus_out_r        <= '0;
        a_bus_out_parity_r <= 1'b0;
        a_tags_out_r       <= '0;
        b_bus_in_r         <= '0;
        b_bus_in_parity_r  <= 1'b0;
        // Outbound select loops back to inbound select while the drivers are not live.
        b_tags_in_r        <= {7'b0, bus.b_tags_out[3], 2'b0};
      end
    end
  end

  assign bus.driver_enable    = driver_enable_r;
  assign bus.a_bus_out        = a_bus_out_r;
  assign bus.a_bus_out_parity = a_bus_out_parity_r;
  assign bus.a_tags_out       = a_tags_out_r;
  assign bus.b_bus_in         = b_bus_in_r;
  assign bus.b_bus_in_parity  = b_bus_in_parity_r;
  assign bus.b_tags_in        = b_tags_in_r;
  assign bus.state            = state_r;

endmodule

// File: tb/tb_frontend_a_seq.sv
// tb_frontend_a_seq: randomized stimulus, reference model derived from the
// frontend's rules, expected values queued per cycle and checked by a monitor.
`timescale 1ns/1ps
module tb_frontend_a_seq;
  localparam int BW   = 8;
  localparam int SS   = 2;
  localparam int FC   = 3;
  localparam int GC   = 16;
  localparam int OFS  = 8;
  localparam int MAXC = 500;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  frontend_a_seq_if #(.BUS_WIDTH(BW)) bus ();

`ifdef FRONTEND_GLITCH_COUNT_EN
  logic        glitch_count_clear;
  logic [15:0] glitch_count;
`endif

  frontend_a_seq #(
    .BUS_WIDTH(BW), .SYNC_STAGES(SS), .FILTER_CYCLES(FC), .GUARD_CYCLES(GC)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
`ifdef FRONTEND_GLITCH_COUNT_EN
    .glitch_count_clear(glitch_count_clear),
    .glitch_count(glitch_count),
`endif
    .bus(bus)
  );

  typedef struct {
    int            cyc;
    logic [1:0]    st;
    logic          de;
    logic [BW-1:0] abo;
    logic          abop;
    logic [10:0]   ato;
    logic [BW-1:0] bbi;
    logic          bbip;
    logic [9:0]    bti;
    logic [15:0]   gc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int checks = 0;
  int errors = 0;

  // stimulus history, index = cycle + OFS (negative cycles = reset values)
  logic          h_en   [MAXC+OFS];
  logic [BW-1:0] h_pbus [MAXC+OFS];
  logic          h_ppar [MAXC+OFS];
  logic [9:0]    h_ptag [MAXC+OFS];
  logic [BW-1:0] h_bbo  [MAXC+OFS];
  logic          h_bbop [MAXC+OFS];
  logic [10:0]   h_bto  [MAXC+OFS];
  logic          h_clr  [MAXC+OFS];
  logic [9:0]    h_filt [MAXC+OFS];
  logic [15:0]   h_gc   [MAXC+OFS];
  int m_st;
  int m_since;

  task automatic chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // true-polarity tag value seen by the logic during cycle u
  function automatic logic [9:0] samp(input int u);
    return ~h_ptag[u - SS + OFS];
  endfunction

  task automatic drive_defaults();
    bus.enable = 1'b0;
    bus.a_bus_in_n = '1;
    bus.a_bus_in_parity_n = 1'b1;
    bus.a_tags_in_n = '1;
    bus.b_bus_out = '0;
    bus.b_bus_out_parity = 1'b0;
    bus.b_tags_out = '0;
`ifdef FRONTEND_GLITCH_COUNT_EN
    glitch_count_clear = 1'b0;
`endif
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_driver_enable"}, -1, 32'(bus.driver_enable), 32'd0);
    chk({tag, "_state"}, -1, 32'(bus.state), 32'd0);
    chk({tag, "_a_bus_out"}, -1, 32'(bus.a_bus_out), 32'd0);
    chk({tag, "_a_tags_out"}, -1, 32'(bus.a_tags_out), 32'd0);
    chk({tag, "_b_tags_in"}, -1, 32'(bus.b_tags_in), 32'd0);
    chk({tag, "_b_bus_in"}, -1, 32'(bus.b_bus_in), 32'd0);
  endtask

  // Runs n cycles starting at cycle 0 (called #1 after the edge where reset_n rose).
  task automatic run_epoch(input int n, input int mode);
    logic en_cur;
    en_cur = 1'b1;
    for (int k = 0; k < OFS; k++) begin
      h_en[k] = 1'b0; h_pbus[k] = '1; h_ppar[k] = 1'b1; h_ptag[k] = '1;
      h_bbo[k] = '0; h_bbop[k] = 1'b0; h_bto[k] = '0; h_clr[k] = 1'b0;
      h_filt[k] = '0; h_gc[k] = '0;
    end
    for (int t = 0; t < n; t++) begin
      int i;
      exp_t e;
      logic [9:0] f;
      logic uni;
      logic ab;
      i = t + OFS;
      if (t > 0) begin
        @(posedge clk);
        #1;
      end
      // sequencer: timestamps of entering ARM / DRAIN
      if (t == 0) begin
        m_st = 0; m_since = 0;
      end else begin
        case (m_st)
          0: if (h_en[i-1]) begin m_st = 1; m_since = t; end
          1: if (!h_en[i-1]) begin m_st = 3; m_since = t; end
             else if (t - m_since == GC) m_st = 2;
          2: if (!h_en[i-1]) begin m_st = 3; m_since = t; end
          default: if (t - m_since == GC) m_st = 0;
        endcase
      end
      // filter: takes a value once the last FC samples all agree on it
      f = '0;
      if (t > 0) begin
        for (int b = 0; b < 10; b++) begin
          uni = 1'b1;
          for (int k = 1; k <= FC; k++) if (samp(t-k)[b] != samp(t-1)[b]) uni = 1'b0;
          f[b] = uni ? samp(t-1)[b] : h_filt[i-1][b];
        end
      end
      h_filt[i] = f;
      // glitch: previous cycle had an open run (differing sample, no update) and the sample came back
      ab = 1'b0;
      if (t > 0) begin
        for (int b = 0; b < 10; b++) begin
          if (samp(t-1)[b] == h_filt[i-1][b] && samp(t-2)[b] != h_filt[i-2][b] &&
              h_filt[i-1][b] == h_filt[i-2][b]) ab = 1'b1;
        end
      end
      if (t == 0 || h_clr[i-1]) h_gc[i] = 16'h0000;
      else if (ab && h_gc[i-1] != 16'hFFFF) h_gc[i] = h_gc[i-1] + 16'h0001;
      else h_gc[i] = h_gc[i-1];

      e.cyc = t; e.st = 2'(m_st); e.de = (m_st != 0); e.gc = h_gc[i];
      if (m_st == 2) begin
        e.abo = h_bbo[i-1]; e.abop = h_bbop[i-1]; e.ato = h_bto[i-1];
        e.bbi = ~h_pbus[i-SS-1]; e.bbip = ~h_ppar[i-SS-1]; e.bti = f;
      end else begin
        e.abo = '0; e.abop = 1'b0; e.ato = '0; e.bbi = '0; e.bbip = 1'b0;
        e.bti = 10'(h_bto[i-1][3]) << 2;
      end
      exp_q.push_back(e);

      // stimulus for this cycle
      if (mode == 0) begin
        if (t < 60) en_cur = 1'b1;
        else if (t < 80) en_cur = 1'b0;
        else if (t < 86) en_cur = 1'b1;
        else if (t == 86) en_cur = 1'b0;
        else if (t < 200) en_cur = 1'b1;
        else if (t < 360) begin if ($urandom_range(0, 29) == 0) en_cur = ~en_cur; end
        else en_cur = 1'b1;
      end else begin
        if (t < 30) en_cur = 1'b1;
        else if ($urandom_range(0, 24) == 0) en_cur = ~en_cur;
      end
      h_en[i] = en_cur;
      h_pbus[i] = BW'($urandom);
      h_ppar[i] = 1'($urandom);
      h_ptag[i] = h_ptag[i-1];
      for (int b = 0; b < 10; b++) if ($urandom_range(0, 4) == 0) h_ptag[i][b] = ~h_ptag[i][b];
      h_bbo[i] = BW'($urandom);
      h_bbop[i] = 1'($urandom);
      h_bto[i] = 11'($urandom);
      h_clr[i] = ($urandom_range(0, 49) == 0);
      bus.enable = h_en[i];
      bus.a_bus_in_n = h_pbus[i];
      bus.a_bus_in_parity_n = h_ppar[i];
      bus.a_tags_in_n = h_ptag[i];
      bus.b_bus_out = h_bbo[i];
      bus.b_bus_out_parity = h_bbop[i];
      bus.b_tags_out = h_bto[i];
`ifdef FRONTEND_GLITCH_COUNT_EN
      glitch_count_clear = h_clr[i];
`endif
    end
  endtask

  // Monitor: one queued expectation per cycle, compared away from the active edge.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      chk("state", mon_e.cyc, 32'(bus.state), 32'(mon_e.st));
      chk("driver_enable", mon_e.cyc, 32'(bus.driver_enable), 32'(mon_e.de));
      chk("a_bus_out", mon_e.cyc, 32'(bus.a_bus_out), 32'(mon_e.abo));
      chk("a_bus_out_parity", mon_e.cyc, 32'(bus.a_bus_out_parity), 32'(mon_e.abop));
      chk("a_tags_out", mon_e.cyc, 32'(bus.a_tags_out), 32'(mon_e.ato));
      chk("b_bus_in", mon_e.cyc, 32'(bus.b_bus_in), 32'(mon_e.bbi));
      chk("b_bus_in_parity", mon_e.cyc, 32'(bus.b_bus_in_parity), 32'(mon_e.bbip));
      chk("b_tags_in", mon_e.cyc, 32'(bus.b_tags_in), 32'(mon_e.bti));
`ifdef FRONTEND_GLITCH_COUNT_EN
      chk("glitch_count", mon_e.cyc, 32'(glitch_count), 32'(mon_e.gc));
`endif
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive_defaults();
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset_n = 1'b1;
    run_epoch(420, 0);
    @(negedge clk);
    #2;
    chk("queue_drain_1", -1, 32'(exp_q.size()), 32'd0);
    // asynchronous reset while ON: outputs must drop without a clock edge
    reset_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    drive_defaults();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    run_epoch(300, 1);
    @(negedge clk);
    #2;
    chk("queue_drain_2", -1, 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/frontend_a_seq.md
Name: frontend_a_seq

Overview:
- Parametrised successor to the Channel "A" frontend. Bridges the internal Channel "B" tag/bus interface to the physical active-low Channel "A" receivers and drivers.
- Adds configurable bus width, synchroniser depth and tag glitch filtering.
- Adds a sequenced driver power-up/power-down state machine that guarantees guard time between driver_enable and live outputs.
- Sits between the channel engine and the board I/O pins.

Parameters:
BUS_WIDTH, 8, width of bus_in/bus_out (parity stays 1 bit)
SYNC_STAGES, 2, synchroniser flops per inbound signal (min 2)
FILTER_CYCLES, 3, consecutive equal synchronised samples needed before an inbound tag changes (1 = no filter)
GUARD_CYCLES, 16, cycles drivers stay enabled with outputs held 0, on arm and on drain (min 1)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
enable  in  1  request frontend active
a_bus_in_n  in  BUS_WIDTH  raw bus-in, active low
a_bus_in_parity_n  in  1  raw bus-in parity, active low
a_tags_in_n  in  10  raw inbound tags, active low: [0]mark_0 [1]request [2]select [3]operational [4]address [5]status [6]service [7]data [8]disconnect [9]metering
a_bus_out  out  BUS_WIDTH  bus-out to drivers
a_bus_out_parity  out  1  bus-out parity
a_tags_out  out  11  outbound tags: [0]mark_0 [1]operational [2]hold [3]select [4]address [5]command [6]service [7]suppress [8]data [9]metering [10]clock
driver_enable  out  1  line driver enable
b_bus_in  out  BUS_WIDTH  true-polarity bus-in to channel engine
b_bus_in_parity  out  1  true-polarity parity
b_tags_in  out  10  true-polarity inbound tags, same bit map as a_tags_in_n
b_bus_out  in  BUS_WIDTH  bus-out from engine
b_bus_out_parity  in  1  bus-out parity from engine
b_tags_out  in  11  outbound tags from engine, same bit map as a_tags_out
state  out  2  0 OFF, 1 ARM, 2 ON, 3 DRAIN

Behaviour:
- Reset (async, reset_n low):
  - All outputs 0; state=OFF.
  - Synchroniser chains set all-ones (deasserted).
  - Filter outputs 0, run counters 0, guard counter 0.
- Synchroniser: every a_* input passes through SYNC_STAGES flops, then inverts.
- Bus/parity path: unfiltered. In ON, b_bus_in = ~synchronised value with latency SYNC_STAGES+1 cycles from pin.
- Tag filter, per bit:
  - Tracks the run length of a synchronised sample differing from the filter output.
  - When the run reaches FILTER_CYCLES, filter output takes the new value and the run clears.
  - If the sample returns to the filter output value first, the run clears (glitch).
  - Tag latency to b_tags_in in ON: SYNC_STAGES+FILTER_CYCLES cycles.
  - Filter runs in all states; only output gating depends on state.
- State machine, guard counter counts 0..GUARD_CYCLES-1:
  - OFF: driver_enable=0; a_* outputs 0; b_* inputs 0 except b_tags_in[2]=b_tags_out[3] (select loopback, registered). enable=1 -> ARM, counter cleared.
  - ARM: driver_enable=1; outputs and b_* as OFF. Counter reaches GUARD_CYCLES-1 with enable=1 -> ON. enable=0 -> DRAIN, counter cleared.
  - ON: driver_enable=1; a_bus_out, a_bus_out_parity, a_tags_out register b_* with 1-cycle latency; b_* inbound driven from sync/filter paths. enable=0 -> DRAIN, counter cleared.
  - DRAIN: driver_enable=1; outputs forced 0 the first cycle in DRAIN; b_* as OFF. Counter reaches GUARD_CYCLES-1 -> OFF regardless of enable. enable=1 during DRAIN is ignored until OFF is reached; OFF then re-arms next cycle.
- driver_enable, state and all outputs are registered.
- Reset mid-ON: outputs and driver_enable drop to 0 immediately; no drain.

Optional Feature:
- Macro FRONTEND_GLITCH_COUNT_EN.
- Defined: adds ports glitch_count_clear (in, 1) and glitch_count (out, 16).
  - Counter increments by 1 on any cycle where at least one tag bit abandons a run.
  - Saturates at 16'hFFFF.
  - glitch_count_clear=1 zeroes it; clear wins over a same-cycle increment.
  - Reset value 0.
- Undefined: ports absent, no counter logic.

Test Plan:
- Reset, enable=1 at cycle 0, GUARD_CYCLES=16 -> driver_enable=1 at cycle 1, state=ON and first live a_tags_out at cycle 17; outputs 0 before that.
- ON, b_bus_out=8'hA5, b_tags_out=11'h7FF -> a_bus_out=8'hA5, a_tags_out=11'h7FF one cycle later. Drop enable -> outputs 0 next cycle, driver_enable=0 after 16 DRAIN cycles.
- ON, a_bus_in_n=8'h5A -> b_bus_in=8'hA5 after 3 cycles (SYNC_STAGES=2).
- ON, FILTER_CYCLES=3, a_tags_in_n[6] low for 2 cycles -> b_tags_in[6] stays 0, glitch_count=1 (macro on). Low for 3+ cycles -> b_tags_in[6]=1 after 5 cycles.
- OFF, b_tags_out[3] toggled -> b_tags_in[2] follows one cycle later; a_tags_out stays 0.
- enable pulsed low then high during ARM -> DRAIN full 16 cycles, OFF one cycle, ARM again. Async reset_n low mid-ON -> all outputs 0 without waiting for a clock edge.
